// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit MCU control path: opcode constants, ALU
// operation encodings, the sequencer state enum and the instruction field
// positions. The assembler and the ALU use the same field layout, so every
// field extraction goes through the helpers below rather than raw slices.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes (ir[15:12]). Codes A..E are unassigned and execute as NOP.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operation encodings driven on alu_op.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  // Instruction field positions.
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Sequencer states. Every instruction walks FETCH..WRITEBACK once.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  function automatic logic [3:0] f_opcode(input logic [15:0] ir);
    return ir[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [2:0] f_rd(input logic [15:0] ir);
    return ir[RD_HI:RD_LO];
  endfunction

  function automatic logic [2:0] f_rs1(input logic [15:0] ir);
    return ir[RS1_HI:RS1_LO];
  endfunction

  function automatic logic [2:0] f_rs2(input logic [15:0] ir);
    return ir[RS2_HI:RS2_LO];
  endfunction

  function automatic logic [7:0] f_imm(input logic [15:0] ir);
    return ir[IMM_HI:IMM_LO];
  endfunction

  // ALU operation for an opcode; anything that is not an ALU opcode gets ADD
  // (000) so the ALU input is quiet and predictable.
  function automatic logic [2:0] alu_op_of(input logic [3:0] opc);
    logic [2:0] op;
    op = ALU_ADD;
    case (opc)
      OP_ADD:  op = ALU_ADD;
      OP_SUB:  op = ALU_SUB;
      OP_AND:  op = ALU_AND;
      OP_OR:   op = ALU_OR;
      OP_XOR:  op = ALU_XOR;
      OP_MOV:  op = ALU_PASS;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational decode of the held instruction register.
// Ports:
//   i_ir            in  16  instruction register
//   o_read_addr1    out 3   register-file port 1 address (rd for BEQZ, else rs1)
//   o_read_addr2    out 3   register-file port 2 address (rs2)
//   o_write_addr    out 3   register-file write address (rd)
//   o_alu_op        out 3   ALU operation
//   o_imm           out 8   immediate field
//   o_writes_reg    out 1   opcode writes rd (opcodes 1..7)
//   o_use_imm       out 1   result comes from imm instead of the ALU (LDI)
//   o_is_jmp        out 1   unconditional jump
//   o_is_beqz       out 1   branch if source register is zero
//   o_is_halt       out 1   halt instruction
// -----------------------------------------------------------------------------
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [2:0]  o_read_addr1,
  output logic [2:0]  o_read_addr2,
  output logic [2:0]  o_write_addr,
  output logic [2:0]  o_alu_op,
  output logic [7:0]  o_imm,
  output logic        o_writes_reg,
  output logic        o_use_imm,
  output logic        o_is_jmp,
  output logic        o_is_beqz,
  output logic        o_is_halt
);

  logic [3:0] w_opc;

  assign w_opc = f_opcode(i_ir);

  always_comb begin
    o_writes_reg = 1'b0;
    o_use_imm    = 1'b0;
    o_is_jmp     = 1'b0;
    o_is_beqz    = 1'b0;
    o_is_halt    = 1'b0;
    case (w_opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: o_writes_reg = 1'b1;
      OP_LDI: begin
        o_writes_reg = 1'b1;
        o_use_imm    = 1'b1;
      end
      OP_JMP:  o_is_jmp  = 1'b1;
      OP_BEQZ: o_is_beqz = 1'b1;
      OP_HALT: o_is_halt = 1'b1;
      default: ;
    endcase
  end

  // BEQZ tests the register named in the rd slot, so port 1 is steered there.
  assign o_read_addr1 = o_is_beqz ? f_rd(i_ir) : f_rs1(i_ir);
  assign o_read_addr2 = f_rs2(i_ir);
  assign o_write_addr = f_rd(i_ir);
  assign o_alu_op     = alu_op_of(w_opc);
  assign o_imm        = f_imm(i_ir);

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Four-cycle FETCH / DECODE / EXECUTE / WRITEBACK sequencer for the 8-bit MCU,
// with an absorbing HALT state. Owns the PC, the instruction register, the
// latched result and the branch-taken flag; decode is in instr_decoder.
// Parameters:
//   PC_W      program-counter width (program memory is 2^PC_W words)
//   RESET_PC  PC value loaded by reset
// Ports:
//   clk          in  1     rising-edge clock
//   reset        in  1     synchronous, active-high
//   pc_out       out PC_W  program-memory address
//   instr_in     in  16    program-memory data, one cycle after pc_out
//   read_addr1   out 3     register-file read address 1
//   read_addr2   out 3     register-file read address 2
//   read_data1   in  8     register-file read data 1 (combinational)
//   read_data2   in  8     register-file read data 2 (feeds the ALU only)
//   write_addr   out 3     register-file write address
//   write_data   out 8     register-file write data
//   reg_write    out 1     register-file write strobe (WRITEBACK only)
//   alu_op       out 3     ALU operation
//   alu_result   in  8     ALU combinational result
//   halted       out 1     high while in HALT
// -----------------------------------------------------------------------------
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] pc_out,
  input  logic [15:0]     instr_in,
  output logic [2:0]      read_addr1,
  output logic [2:0]      read_addr2,
  input  logic [7:0]      read_data1,
  input  logic [7:0]      read_data2,
  output logic [2:0]      write_addr,
  output logic [7:0]      write_data,
  output logic            reg_write,
  output logic [2:0]      alu_op,
  input  logic [7:0]      alu_result,
  output logic            halted
);

  // imm is 8 bits wide; zero-extend or truncate it onto the PC width.
  function automatic logic [PC_W-1:0] imm_to_pc(input logic [7:0] imm);
    logic [PC_W+7:0] w_ext;
    w_ext = {{PC_W{1'b0}}, imm};
    return w_ext[PC_W-1:0];
  endfunction

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [7:0]      r_result_q;
  logic            r_take_q;

  logic [7:0]      w_imm;
  logic            w_writes_reg;
  logic            w_use_imm;
  logic            w_is_jmp;
  logic            w_is_beqz;
  logic            w_is_halt;
  logic            w_src_zero;
  logic            w_unused_rd2;

  instr_decoder u_dec (
    .i_ir         (r_ir),
    .o_read_addr1 (read_addr1),
    .o_read_addr2 (read_addr2),
    .o_write_addr (write_addr),
    .o_alu_op     (alu_op),
    .o_imm        (w_imm),
    .o_writes_reg (w_writes_reg),
    .o_use_imm    (w_use_imm),
    .o_is_jmp     (w_is_jmp),
    .o_is_beqz    (w_is_beqz),
    .o_is_halt    (w_is_halt)
  );

  // read_data2 only reaches the ALU; the sequencer never inspects it.
  assign w_unused_rd2 = ^read_data2;

  assign w_src_zero = (read_data1 == 8'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_FETCH;
      r_pc       <= PC_W'(RESET_PC);
      r_ir       <= 16'h0000;
      r_result_q <= 8'h00;
      r_take_q   <= 1'b0;
    end else begin
      case (r_state)
        // FETCH: pc_out already presents r_pc to program memory.
        ST_FETCH: begin
          r_state <= ST_DECODE;
        end
        // DECODE: memory data for r_pc is valid now.
        ST_DECODE: begin
          r_ir    <= instr_in;
          r_state <= ST_EXECUTE;
        end
        // EXECUTE: register reads and the ALU settle off the new IR.
        ST_EXECUTE: begin
          r_result_q <= w_use_imm ? w_imm : alu_result;
          r_take_q   <= w_is_jmp | (w_is_beqz & w_src_zero);
          r_state    <= ST_WRITEBACK;
        end
        // WRITEBACK: register file commits on this edge; PC advances.
        ST_WRITEBACK: begin
          r_pc    <= r_take_q ? imm_to_pc(w_imm) : r_pc + PC_W'(1);
          r_state <= w_is_halt ? ST_HALT : ST_FETCH;
        end
        // HALT: everything frozen until reset.
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign pc_out     = r_pc;
  assign write_data = r_result_q;
  // Gated by reset so an interrupted WRITEBACK never commits.
  assign reg_write  = (r_state == ST_WRITEBACK) && w_writes_reg && !reset;
  assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [7:0]  pc_out;
  logic [15:0] instr_in;
  logic [2:0]  read_addr1, read_addr2, write_addr, alu_op;
  logic [7:0]  read_data1, read_data2, write_data, alu_result;
  logic        reg_write, halted;

  control_unit #(.PC_W(8), .RESET_PC(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_out     (pc_out),
    .instr_in   (instr_in),
    .read_addr1 (read_addr1),
    .read_addr2 (read_addr2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .write_addr (write_addr),
    .write_data (write_data),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: program memory, register file and ALU.
  logic [15:0] mem [256];
  logic [7:0]  rf [8];
  logic [7:0]  rf_init [8];
  logic        rf_load;

  always @(posedge clk) instr_in <= mem[pc_out];

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
    end else if (reg_write) begin
      rf[write_addr] <= write_data;
    end
  end

  assign read_data1 = rf[read_addr1];
  assign read_data2 = rf[read_addr2];

  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      3'b000: alu_result = read_data1 + read_data2;
      3'b001: alu_result = read_data1 - read_data2;
      3'b010: alu_result = read_data1 & read_data2;
      3'b011: alu_result = read_data1 | read_data2;
      3'b100: alu_result = read_data1 ^ read_data2;
      3'b101: alu_result = read_data1;
      default: alu_result = 8'h00;
    endcase
  end

  // Scoreboard
  typedef struct {
    int         cyc;
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] pq[$];
  logic [7:0] mreg [8];

  int checks;
  int errors;
  int cyc;
  bit halt_seen;
  int halt_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Instruction-level reference: runs the program straight from the ISA rules
  // and records, per instruction, its fetch address and any register write
  // with the cycle (counted from the first FETCH) where it must appear.
  task automatic model_run(input int max_instr, output int nexec,
                           output bit mhalt, output logic [7:0] mpc);
    logic [7:0]  pc, a, b, imm, res;
    logic [15:0] ins;
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    bit          wr;
    wr_t         e;
    pc = 8'h00;
    mhalt = 1'b0;
    nexec = 0;
    for (int i = 0; i < 8; i++) mreg[i] = rf_init[i];
    for (int i = 0; i < max_instr && !mhalt; i++) begin
      pq.push_back(pc);
      ins = mem[pc];
      op  = ins[15:12];
      rd  = ins[11:9];
      rs1 = ins[8:6];
      rs2 = ins[5:3];
      imm = ins[7:0];
      a   = mreg[rs1];
      b   = mreg[rs2];
      wr  = 1'b1;
      res = 8'h00;
      case (op)
        4'd1: res = a + b;
        4'd2: res = a - b;
        4'd3: res = a & b;
        4'd4: res = a | b;
        4'd5: res = a ^ b;
        4'd6: res = a;
        4'd7: res = imm;
        default: wr = 1'b0;
      endcase
      if (op == 4'd8) pc = imm;
      else if (op == 4'd9 && mreg[rd] == 8'h00) pc = imm;
      else pc = pc + 8'd1;
      if (wr) begin
        mreg[rd] = res;
        e.cyc = 4 * (i + 1);
        e.a   = rd;
        e.d   = res;
        wq.push_back(e);
      end
      if (op == 4'hF) mhalt = 1'b1;
      nexec = i + 1;
    end
    mpc = pc;
  endtask

  // Monitor: pops expectations whenever the DUT writes or fetches.
  task automatic monitor();
    wr_t e;
    logic [7:0] p;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0;
        halt_seen = 1'b0;
      end else begin
        cyc++;
        if (reg_write) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %0h at cycle %0d, required none",
                     write_addr, write_data, cyc);
          end else begin
            e = wq.pop_front();
            chk("write_cycle", cyc, e.cyc);
            chk("write_addr", {29'd0, write_addr}, {29'd0, e.a});
            chk("write_data", {24'd0, write_data}, {24'd0, e.d});
          end
        end
        if ((cyc % 4) == 1 && pq.size() > 0) begin
          p = pq.pop_front();
          chk("fetch_pc", {24'd0, pc_out}, {24'd0, p});
        end
        if (halted && !halt_seen) begin
          halt_seen = 1'b1;
          halt_cyc  = cyc;
        end
      end
    end
  endtask

  task automatic enter_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rf_load = 1'b1;
    @(posedge clk);
    #1 rf_load = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic clear_env();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rf_init[i] = 8'h00;
    wq.delete();
    pq.delete();
  endtask

  task automatic run_prog(input int max_instr);
    int n;
    bit mh;
    logic [7:0] mpc;
    model_run(max_instr, n, mh, mpc);
    release_reset();
    repeat (4 * n) @(posedge clk);
    @(negedge clk);
    #1;
    chk("halted", {31'd0, halted}, {31'd0, mh});
    chk("pc_after", {24'd0, pc_out}, {24'd0, mpc});
    if (mh) chk("halt_cycle", halt_cyc, 4 * n + 1);
    chk("write_queue_left", wq.size(), 0);
    chk("fetch_queue_left", pq.size(), 0);
    for (int i = 0; i < 8; i++) chk("regfile", {24'd0, rf[i]}, {24'd0, mreg[i]});
    if (mh) begin
      repeat (20) begin
        @(negedge clk);
        chk("halt_reg_write", {31'd0, reg_write}, 32'd0);
        chk("halt_pc", {24'd0, pc_out}, {24'd0, mpc});
        chk("halt_hold", {31'd0, halted}, 32'd1);
      end
    end
  endtask

  task automatic stimulus();
    logic [3:0] op;
    // Reset values, then LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT.
    enter_reset();
    clear_env();
    mem[0] = 16'h7205;
    mem[1] = 16'h7403;
    mem[2] = 16'h1650;
    mem[3] = 16'hF000;
    @(negedge clk);
    chk("rst_pc_out", {24'd0, pc_out}, 32'd0);
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_write_data", {24'd0, write_data}, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_read_addr1", {29'd0, read_addr1}, 32'd0);
    chk("rst_read_addr2", {29'd0, read_addr2}, 32'd0);
    chk("rst_write_addr", {29'd0, write_addr}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    run_prog(10);
    chk("ldi_add_r3", {24'd0, rf[3]}, 32'd8);

    // Reset leaves HALT and returns the PC to 0.
    enter_reset();
    @(negedge clk);
    chk("halt_reset_pc", {24'd0, pc_out}, 32'd0);
    chk("halt_reset_halted", {31'd0, halted}, 32'd0);

    // BEQZ r0,0x10 taken.
    clear_env();
    mem[0]    = 16'h9010;
    mem[8'h10] = 16'hF000;
    run_prog(4);
    chk("beqz_taken_pc", {24'd0, pc_out}, 32'h11);

    // BEQZ r0,0x10 not taken with r0 = 7.
    enter_reset();
    clear_env();
    rf_init[0] = 8'h07;
    mem[0] = 16'h9010;
    mem[1] = 16'hF000;
    run_prog(4);
    chk("beqz_not_taken_pc", {24'd0, pc_out}, 32'h02);

    // JMP 0x00 located at 0xFF.
    enter_reset();
    clear_env();
    mem[0]    = 16'h80FF;
    mem[8'hFF] = 16'h8000;
    run_prog(2);

    // NOP at 0xFF wraps to 0.
    enter_reset();
    clear_env();
    mem[0]    = 16'h80FF;
    mem[8'hFF] = 16'h0000;
    run_prog(2);

    // Opcodes A..E write nothing.
    enter_reset();
    clear_env();
    for (int i = 0; i < 8; i++) rf_init[i] = 8'(i * 17 + 3);
    mem[0] = 16'hA249;
    mem[1] = 16'hB6DB;
    mem[2] = 16'hCFFF;
    mem[3] = 16'hD001;
    mem[4] = 16'hE8AA;
    mem[5] = 16'hF000;
    run_prog(8);

    // Reset arriving in the WRITEBACK of LDI r4,0xAA.
    enter_reset();
    clear_env();
    rf_init[4] = 8'h11;
    mem[0] = 16'h78AA;
    release_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_in_wb_reg_write", {31'd0, reg_write}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_in_wb_r4", {24'd0, rf[4]}, 32'h11);
    chk("rst_in_wb_pc", {24'd0, pc_out}, 32'd0);

    // Random programs.
    for (int t = 0; t < 8; t++) begin
      enter_reset();
      clear_env();
      for (int i = 0; i < 256; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 9));
        mem[i] = {op, 12'($urandom)};
      end
      for (int i = 0; i < 8; i++)
        rf_init[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run_prog(40);
    end
  endtask

  initial begin
    reset   = 1'b1;
    rf_load = 1'b0;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    halt_seen = 1'b0;
    halt_cyc  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      rf_init[i] = 8'h00;
      mreg[i]    = 8'h00;
    end
    fork
      monitor();
      begin
        stimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit MCU. It sits directly upstream of the 8×8-bit register file.
- Fetches 16-bit instructions from program memory and decodes them.
- Drives the register file's read/write addresses, `reg_write` strobe and `write_data`.
- Selects the ALU operation, and owns the program counter, branch and halt logic.

## Interface
Parameters:
- `PC_W`, 8: program-counter width; program memory depth is 2^PC_W words.
- `RESET_PC`, 0: PC value loaded by reset.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pc_out` out PC_W: program-memory address.
- `instr_in` in 16: program-memory data; synchronous read, valid one cycle after `pc_out`.
- `read_addr1`, `read_addr2` out 3: register-file read addresses.
- `read_data1`, `read_data2` in 8: register-file read data (combinational).
- `write_addr` out 3: register-file write address.
- `write_data` out 8: register-file write data.
- `reg_write` out 1: register-file write strobe.
- `alu_op` out 3: ALU operation code.
- `alu_result` in 8: ALU combinational result.
- `halted` out 1: high while in HALT.

## Operation
- Instruction fields:
  - opcode `ir[15:12]`, rd `ir[11:9]`, rs1 `ir[8:6]`, rs2 `ir[5:3]`, imm `ir[7:0]`.
  - BEQZ takes its source register from `ir[11:9]`.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: `rd <= rs1 op rs2`.
  - 6 MOV: `rd <= rs1`.
  - 7 LDI: `rd <= imm`.
  - 8 JMP: `pc <= imm`.
  - 9 BEQZ: if `reg[ir[11:9]] == 0` then `pc <= imm`.
  - F HALT.
  - A–E execute as NOP.
- `alu_op` encodings: ADD 000, SUB 001, AND 010, OR 011, XOR 100, PASS 101 (PASS returns `read_data1`). For non-ALU opcodes `alu_op` is 000.
- `read_addr1` = `ir[11:9]` for BEQZ, otherwise `ir[8:6]`. `read_addr2` = `ir[5:3]`. `write_addr` = `ir[11:9]`.
- Register-writing opcodes are 1–7. LDI selects `imm` as `result_q`; all others select `alu_result`.
- FSM states: FETCH → DECODE → EXECUTE → WRITEBACK → FETCH, plus HALT.
  - FETCH: `pc_out = pc`.
  - DECODE: `ir <= instr_in`.
  - EXECUTE:
    - `result_q <= alu_result` or `imm`.
    - `take_q <= (JMP) | (BEQZ & read_data1 == 0)`.
  - WRITEBACK:
    - `reg_write = 1` if the opcode writes a register; `write_data = result_q`.
    - `pc <= take_q ? imm : pc + 1`.
    - Next state is HALT if the opcode is HALT, otherwise FETCH.
  - HALT: absorbing. `pc` and `ir` are frozen, `reg_write = 0`, `halted = 1`. Only `reset` leaves HALT.
- PC arithmetic is modulo 2^PC_W: `pc + 1` wraps from 255 to 0. `imm` is zero-extended or truncated to PC_W.

## Timing
- Every instruction takes 4 cycles; throughput is 1 instruction per 4 clocks. HALT is reached after 4 cycles and stays there.
- `reg_write` is high for exactly 1 cycle per register-writing instruction: the WRITEBACK cycle. The register file commits on the edge that ends WRITEBACK.
- Read-after-write: the following instruction's EXECUTE occurs 3 cycles after that edge, so no forwarding is needed.
- Reset values:
  - `state` = FETCH, `pc` = `pc_out` = RESET_PC.
  - `ir` = 0 (NOP), `result_q` = 0, `take_q` = 0.
  - `reg_write` = 0, `write_data` = 0, `alu_op` = 000, all addresses = 0, `halted` = 0.
- Reset mid-operation:
  - `reg_write` is gated by `!reset`, so no register-file write occurs in a reset cycle, even from WRITEBACK.
  - Reset has priority over every state transition, including HALT.
- BEQZ samples `read_data1` only in EXECUTE.
- Reset deassertion: the first FETCH occurs on the first cycle after `reset` is sampled low.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants;
  - `alu_op` encodings;
  - the FSM state enum;
  - the instruction field positions (shared with the assembler and the ALU).
- Sub-module `instr_decoder` (combinational) maps `ir` to: read/write addresses, `alu_op`, `writes_reg`, `use_imm`, `is_jmp`, `is_beqz`, `is_halt`.
- `control_unit` holds the FSM, PC, IR, `result_q` and `take_q`.

## Test plan
- Reset and first fetch: hold `reset` for 2 cycles → all outputs equal their reset values and `pc_out` = 0; the first DECODE latches `mem[0]`.
- LDI/ADD sequence: program `LDI r1,5; LDI r2,3; ADD r3,r1,r2` → `reg_write` pulses at cycles 4, 8 and 12 with `write_addr`/`write_data` = 1/5, 2/3 and 3/8 respectively.
- Branches:
  - `BEQZ r0,0x10` with r0 = 0 → `pc_out` = 0x10 at the next FETCH.
  - With r0 = 7 → `pc_out` = pc + 1.
  - `JMP 0x00` at address 0xFF → next `pc_out` = 0.
  - NOP at address 0xFF → next `pc_out` = 0 (wrap).
- HALT: opcode F → `halted` = 1 from the cycle after WRITEBACK; `pc_out` stays constant and `reg_write` stays 0 for 20 cycles; asserting `reset` returns to `pc_out` = 0.
- Reset during WRITEBACK of `LDI r4,0xAA` → `reg_write` = 0 in the reset cycle and r4 is unchanged; undefined opcodes A–E behave as NOP with no write.
